// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between eight requesters and rr_arbiter8.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       revoked;
    modport master (input req, output gnt, gnt_idx, gnt_valid, revoked);
    modport slave (output req, input gnt, gnt_idx, gnt_valid, revoked);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to revoke any grant held for HOLD_MAX cycles.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input logic clk,
    input logic rst_n,
    rr_arbiter8_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state;
    logic [2:0]  ptr, idx, off, win;
    logic [7:0]  gnt, cnt, rot;
    logic [15:0] dbl;
    logic        valid, rev, expire;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rr_arbiter8: HOLD_MAX must lie in 2..255");
    end

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        dbl = {bus.req, bus.req} >> ptr;
        rot = dbl[7:0];
        off = '0;
        for (int i = 7; i >= 0; i--) off = rot[i] ? 3'(i) : off;
        win = ptr + off;
    end

`ifdef ARB_TIMEOUT_EN
    assign expire = cnt == 8'(HOLD_MAX);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            idx   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
            rev   <= 1'b0;
            cnt   <= '0;
        end else begin
            rev <= 1'b0;
            case (state)
                IDLE: if (|bus.req) begin
                    gnt   <= 8'd1 << win;
                    idx   <= win;
                    valid <= 1'b1;
                    cnt   <= 8'd1;
                    state <= BUSY;
                end
                BUSY: if (!bus.req[idx] || expire) begin
                    gnt   <= '0;
                    valid <= 1'b0;
                    rev   <= bus.req[idx];
                    ptr   <= idx + 3'd1;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + {7'd0, cnt != 8'hFF};
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_idx   = idx;
    assign bus.gnt_valid = valid;
    assign bus.revoked   = rev;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random stimulus against a reference model via a scoreboard queue.
module tb_rr_arbiter8;
`ifdef ARB_TIMEOUT_EN
    localparam int HM = 4;
    localparam bit TO = 1'b1;
`else
    localparam int HM = 16;
    localparam bit TO = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int compared = 0;
    int mismatched = 0;

    rr_arbiter8_if bus ();
    rr_arbiter8 #(.HOLD_MAX(HM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       rev;
    } exp_t;
    exp_t sb[$];

    int         m_busy = 0, m_ptr = 0, m_idx = 0, m_hold = 0;
    logic [7:0] m_gnt = '0;
    logic       m_valid = 1'b0, m_rev = 1'b0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model(input logic [7:0] r, input logic rn);
        m_rev = 1'b0;
        if (!rn) begin
            m_busy = 0; m_ptr = 0; m_idx = 0; m_hold = 0; m_gnt = '0; m_valid = 1'b0;
        end else if (m_busy == 0) begin
            for (int k = 7; k >= 0; k--) if (r[(m_ptr + k) % 8]) m_idx = (m_ptr + k) % 8;
            if (r != 8'h00) begin
                m_busy = 1; m_hold = 1; m_gnt = 8'h01 << m_idx; m_valid = 1'b1;
            end
        end else if (!r[m_idx] || (TO && m_hold == HM)) begin
            m_rev = r[m_idx];
            m_busy = 0; m_gnt = '0; m_valid = 1'b0; m_ptr = (m_idx + 1) % 8;
        end else if (m_hold < 255) begin
            m_hold++;
        end
    endtask

    task automatic tick(input logic [7:0] r, input logic rn, input string tag);
        exp_t e;
        bus.req = r;
        rst_n = rn;
        model(r, rn);
        e = '{tag, m_gnt, 3'(m_idx), m_valid, m_rev};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".gnt"}, bus.gnt, e.gnt);
        check({e.tag, ".idx"}, {5'd0, bus.gnt_idx}, {5'd0, e.idx});
        check({e.tag, ".valid"}, {7'd0, bus.gnt_valid}, {7'd0, e.valid});
        check({e.tag, ".revoked"}, {7'd0, bus.revoked}, {7'd0, e.rev});
        check({e.tag, ".onehot"}, {7'd0, $onehot0(bus.gnt)}, 8'd1);
    endtask

    initial begin
        logic [7:0] r, prev;
        bus.req = '0;
        #2;
        tick(8'hFF, 1'b0, "rst0");
        tick(8'hFF, 1'b0, "rst1");
        check("rst_gnt", bus.gnt, 8'h00);
        check("rst_idx", {5'd0, bus.gnt_idx}, 8'd0);
        tick(8'hFF, 1'b1, "first");
        check("first_gnt", bus.gnt, 8'h01);

        for (int o = 0; o < 8; o++) begin
            r = 8'hFF & ~(8'h01 << o);
            tick(8'hFF, 1'b1, "rot_hold");
            tick(8'hFF, 1'b1, "rot_hold");
            tick(r, 1'b1, "rot_drop");
            check("rot_idle", {7'd0, bus.gnt_valid}, 8'd0);
            tick(8'hFF, 1'b1, "rot_grant");
            check("rot_order", {5'd0, bus.gnt_idx}, 8'((o + 1) % 8));
        end

        tick(8'h00, 1'b1, "wrap_rel0");
        tick(8'h20, 1'b1, "wrap_g5");
        tick(8'h00, 1'b1, "wrap_rel5");
        tick(8'h05, 1'b1, "wrap_g0");
        check("wrap_gnt", bus.gnt, 8'h01);
        tick(8'h00, 1'b1, "wrap_rel0b");
        tick(8'h05, 1'b1, "skip_g2");
        check("skip_gnt", bus.gnt, 8'h04);
        tick(8'h00, 1'b1, "skip_rel");

`ifndef ARB_TIMEOUT_EN
        tick(8'h08, 1'b1, "hold_g3");
        check("hold_first", bus.gnt, 8'h08);
        for (int i = 0; i < 10; i++) begin
            tick((i % 2) != 0 ? 8'h88 : 8'h08, 1'b1, "hold");
            check("hold_gnt", bus.gnt, 8'h08);
        end
        tick(8'h80, 1'b1, "hold_rel");
        check("hold_rel_gnt", bus.gnt, 8'h00);
        tick(8'h80, 1'b1, "hold_next");
        check("hold_next_gnt", bus.gnt, 8'h80);
        tick(8'h00, 1'b1, "hold_done");
`endif

        tick(8'h04, 1'b1, "mid_g2");
        tick(8'h00, 1'b1, "mid_rel2");
        tick(8'h10, 1'b1, "mid_g4");
        check("mid_g4_gnt", bus.gnt, 8'h10);
        tick(8'h10, 1'b1, "mid_hold");
        tick(8'h10, 1'b0, "mid_rst");
        check("mid_rst_gnt", bus.gnt, 8'h00);
        check("mid_rst_rev", {7'd0, bus.revoked}, 8'd0);
        tick(8'h09, 1'b1, "mid_after");
        check("mid_ptr0", bus.gnt, 8'h01);
        tick(8'h00, 1'b1, "mid_done");

`ifdef ARB_TIMEOUT_EN
        tick(8'h00, 1'b0, "to_rst");
        tick(8'h03, 1'b1, "to_grant");
        check("to_gnt0", bus.gnt, 8'h01);
        for (int i = 0; i < HM - 1; i++) begin
            tick(8'h03, 1'b1, "to_hold");
            check("to_hold_gnt", bus.gnt, 8'h01);
        end
        tick(8'h03, 1'b1, "to_revoke");
        check("to_rev_gnt", bus.gnt, 8'h00);
        check("to_rev_pulse", {7'd0, bus.revoked}, 8'd1);
        tick(8'h03, 1'b1, "to_next");
        check("to_next_gnt", bus.gnt, 8'h02);
        check("to_next_rev", {7'd0, bus.revoked}, 8'd0);
`endif

        prev = 8'h00;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 3) != 0) ? prev : 8'($urandom_range(0, 255));
            prev = r;
            tick(r, $urandom_range(0, 49) != 0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
